// File: rtl/micro_run_ctrl.sv
// Run controller for a micro-core: resets the core, enables it until halt or a
// cycle limit, then freezes it. Define MICRO_RUN_CTRL_RETIRE_CNT_EN to add a retire counter.
module micro_run_ctrl #(
  parameter int CNT_W      = 16,
  parameter int RST_CYCLES = 1,
  parameter int MAX_CYCLES = 100,
  parameter int AUTO_START = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             halt,
  output logic             core_rst,
  output logic             core_en,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_cnt
`ifdef MICRO_RUN_CTRL_RETIRE_CNT_EN
  ,
  input  logic             retire,
  output logic [CNT_W-1:0] retire_cnt
`endif
);

  if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
    $error("micro_run_ctrl: CNT_W must be in 1..32");
  end
  if (RST_CYCLES < 1 || RST_CYCLES > 255) begin : g_bad_rst_cycles
    $error("micro_run_ctrl: RST_CYCLES must be in 1..255");
  end
  if (MAX_CYCLES < 1 || longint'(MAX_CYCLES) > ((longint'(1) << CNT_W) - 1)) begin : g_bad_max_cycles
    $error("micro_run_ctrl: MAX_CYCLES must be in 1..2^CNT_W-1");
  end

  localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_CYCLES);
  localparam logic [7:0]       RST_LAST = 8'(RST_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_CORE_RST = 2'd1,
    S_RUN      = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  state_t           state;
  logic [7:0]       rst_cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             launch;

  assign cnt_inc = cycle_cnt + CNT_W'(1);
  assign launch  = start && (state == S_IDLE || state == S_DONE);

  // Outputs are set on the transition into each state so they are registered
  // values that always match the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      core_rst  <= 1'b1;
      core_en   <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
      cycle_cnt <= '0;
      rst_cnt   <= '0;
      if (AUTO_START != 0) begin
        state <= S_CORE_RST;
        busy  <= 1'b1;
      end else begin
        state <= S_IDLE;
        busy  <= 1'b0;
      end
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state     <= S_CORE_RST;
            core_rst  <= 1'b1;
            core_en   <= 1'b0;
            busy      <= 1'b1;
            done      <= 1'b0;
            timeout   <= 1'b0;
            cycle_cnt <= '0;
            rst_cnt   <= '0;
          end
        end
        S_CORE_RST: begin
          if (rst_cnt == RST_LAST) begin
            state    <= S_RUN;
            core_rst <= 1'b0;
            core_en  <= 1'b1;
          end else begin
            rst_cnt <= rst_cnt + 8'd1;
          end
        end
        S_RUN: begin
          cycle_cnt <= cnt_inc;
          // halt has priority over the cycle limit when both land together
          if (halt) begin
            state   <= S_DONE;
            core_en <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else if (cnt_inc == MAX_C) begin
            state   <= S_DONE;
            core_en <= 1'b0;
            busy    <= 1'b0;
            timeout <= 1'b1;
          end
        end
      endcase
    end
  end

`ifdef MICRO_RUN_CTRL_RETIRE_CNT_EN
  always_ff @(posedge clk) begin
    if (reset || launch) begin
      retire_cnt <= '0;
    end else if (state == S_RUN && retire && retire_cnt != '1) begin
      retire_cnt <= retire_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_micro_run_ctrl.sv
// Directed self-checking bench for micro_run_ctrl with default parameters.
module tb_micro_run_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        halt = 1'b0;
  logic        core_rst, core_en, busy, done, timeout;
  logic [15:0] cycle_cnt;
`ifdef MICRO_RUN_CTRL_RETIRE_CNT_EN
  logic        retire = 1'b0;
  logic [15:0] retire_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int en_cnt;
  int guard;

  micro_run_ctrl #(
    .CNT_W(16),
    .RST_CYCLES(1),
    .MAX_CYCLES(100),
    .AUTO_START(0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .halt(halt),
    .core_rst(core_rst),
    .core_en(core_en),
    .busy(busy),
    .done(done),
    .timeout(timeout),
    .cycle_cnt(cycle_cnt)
`ifdef MICRO_RUN_CTRL_RETIRE_CNT_EN
    ,
    .retire(retire),
    .retire_cnt(retire_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    // reset
    tick();
    tick();
    reset = 1'b0;
    check("rst_core_rst", core_rst, 1);
    check("rst_core_en", core_en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_timeout", timeout, 0);
    check("rst_cycle_cnt", cycle_cnt, 0);
    tick();
    check("idle_core_rst", core_rst, 1);

    // timeout run: halt held low
    start = 1'b1;
    tick();
    start = 1'b0;
    check("crst_core_rst", core_rst, 1);
    check("crst_core_en", core_en, 0);
    check("crst_busy", busy, 1);
    tick();
    check("run_core_rst", core_rst, 0);
    check("run_core_en", core_en, 1);
    check("run_cnt0", cycle_cnt, 0);
    en_cnt = 0;
    guard = 0;
    while (!timeout && !done && guard < 200) begin
      if (core_en) en_cnt++;
      tick();
      guard++;
    end
    check("to_en_cycles", en_cnt, 100);
    check("to_timeout", timeout, 1);
    check("to_done", done, 0);
    check("to_cycle_cnt", cycle_cnt, 100);
    check("to_core_en", core_en, 0);
    check("to_core_rst", core_rst, 0);
    check("to_busy", busy, 0);
    halt = 1'b1;
    repeat (3) tick();
    halt = 1'b0;
    check("done_hold_timeout", timeout, 1);
    check("done_hold_done", done, 0);
    check("done_hold_cnt", cycle_cnt, 100);

    // restart from DONE, start ignored in RUN, halt on 37th RUN cycle
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_cnt", cycle_cnt, 0);
    check("restart_timeout", timeout, 0);
    check("restart_done", done, 0);
    check("restart_busy", busy, 1);
    tick();
    for (int i = 1; i <= 36; i++) begin
      start = (i == 10);
      tick();
    end
    start = 1'b0;
    check("h37_pre_cnt", cycle_cnt, 36);
    check("h37_pre_en", core_en, 1);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    check("h37_done", done, 1);
    check("h37_timeout", timeout, 0);
    check("h37_cnt", cycle_cnt, 37);
    check("h37_core_en", core_en, 0);

    // halt coinciding with the cycle limit
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    repeat (99) tick();
    check("h100_pre_cnt", cycle_cnt, 99);
    check("h100_pre_timeout", timeout, 0);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    check("h100_done", done, 1);
    check("h100_timeout", timeout, 0);
    check("h100_cnt", cycle_cnt, 100);

    // reset on 20th RUN cycle
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    repeat (19) tick();
    check("r20_pre_cnt", cycle_cnt, 19);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("r20_core_rst", core_rst, 1);
    check("r20_core_en", core_en, 0);
    check("r20_busy", busy, 0);
    check("r20_cnt", cycle_cnt, 0);
    check("r20_done", done, 0);
    check("r20_timeout", timeout, 0);
    tick();
    check("r20_idle_busy", busy, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    repeat (4) tick();
    halt = 1'b1;
    tick();
    halt = 1'b0;
    check("after_r_done", done, 1);
    check("after_r_cnt", cycle_cnt, 5);

`ifdef MICRO_RUN_CTRL_RETIRE_CNT_EN
    reset = 1'b1;
    tick();
    reset = 1'b0;
    retire = 1'b1;
    repeat (3) tick();
    check("ret_idle", retire_cnt, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    for (int i = 0; i < 100; i++) begin
      retire = ((i % 5) < 3);
      tick();
    end
    check("ret_timeout", timeout, 1);
    check("ret_cnt", retire_cnt, 60);
    retire = 1'b1;
    repeat (3) tick();
    check("ret_hold", retire_cnt, 60);
    retire = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
